// File: rtl/kbd_cmd_seq.sv
// -----------------------------------------------------------------------------
// kbd_cmd_seq
//   Host-side command sequencer for a PS/2-style keyboard. It drives a byte
//   transmit engine and consumes bytes from a receive engine. It runs two
//   command sequences:
//     init : send FF, expect FA, expect AA (self-test), send F4, expect FA
//     led  : send ED, expect FA, send {5'b0,led_val}, expect FA
//   While idle, received bytes are forwarded as scan codes.
//
// Optional build macro:
//   KBD_SEQ_RETRY_EN  - when defined, a FE (resend) reply re-sends the same
//                       byte up to MAX_RETRY times. When undefined, FE aborts
//                       the sequence and no retry counter is built.
//
// Parameters:
//   ACK_TIMEOUT  cycles allowed for a reply byte after each transmitted byte
//   BAT_TIMEOUT  cycles allowed for AA after the reset command is acknowledged
//   MAX_RETRY    resends allowed per byte on FE (retry build only)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   init_req, led_req        request pulses
//   led_val[2:0]             {caps,num,scroll}, captured with led_req
//   tx_ready / tx_valid /    transmit handshake; tx_byte is stable while
//   tx_byte[7:0]             tx_valid is high
//   rx_valid / rx_byte[7:0]  received byte strobe
//   scan_valid/scan_byte     forwarded scan code (idle only), one cycle later
//   busy                     state is not IDLE
//   done                     one-cycle pulse on sequence success
//   err                      sticky failure flag, cleared on next accepted request
//   state[2:0]               0 IDLE, 1 SEND, 2 WAIT_ACK, 3 WAIT_BAT, 4 DONE, 5 ERR
// -----------------------------------------------------------------------------
module kbd_cmd_seq #(
  parameter int ACK_TIMEOUT = 1000000,
  parameter int BAT_TIMEOUT = 40000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_val,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       scan_valid,
  output logic [7:0] scan_byte,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state
);

  localparam int TMO_W = 26;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_WAIT_BAT = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       tx_byte_reg, tx_byte_next;
  logic             seq_led_reg, seq_led_next;   // 0: init sequence, 1: led sequence
  logic             step_reg, step_next;         // 0: first command byte, 1: second
  logic [2:0]       seq_val_reg, seq_val_next;   // led value of the running sequence
  logic             pend_init_reg, pend_init_next;
  logic             pend_led_reg, pend_led_next;
  logic [2:0]       pend_val_reg, pend_val_next; // latest led value of a pending request
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             err_reg, err_next;
  logic             scan_valid_reg, scan_valid_next;
  logic [7:0]       scan_byte_reg, scan_byte_next;

  logic             start_init;
  logic             start_led;
  logic [2:0]       led_sel;

`ifdef KBD_SEQ_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_cnt_reg, retry_cnt_next;
`else
  // MAX_RETRY only has an effect in the retry build; negative values are
  // meaningless in either build, so nothing is generated for them.
  if (MAX_RETRY < 0) begin : g_retry_cfg_unused
  end
`endif

  // Request arbitration: init wins over led, and a pending request is served
  // in the first IDLE cycle after the previous sequence ends.
  always_comb begin
    start_init = (state_reg == ST_IDLE) && (pend_init_reg || init_req);
    start_led  = (state_reg == ST_IDLE) && !start_init && (pend_led_reg || led_req);
    // A fresh led_req carries the newest value, so it overrides a stored one.
    led_sel    = led_req ? led_val : pend_val_reg;
  end

  always_comb begin
    state_next      = state_reg;
    tx_byte_next    = tx_byte_reg;
    seq_led_next    = seq_led_reg;
    step_next       = step_reg;
    seq_val_next    = seq_val_reg;
    tmo_cnt_next    = '0;
    err_next        = err_reg;
    scan_valid_next = 1'b0;
    scan_byte_next  = scan_byte_reg;
`ifdef KBD_SEQ_RETRY_EN
    retry_cnt_next  = retry_cnt_reg;
`endif

    // Pending flags: a request not started this cycle is remembered.
    pend_init_next = start_init ? 1'b0 : (pend_init_reg || init_req);
    pend_led_next  = start_led  ? 1'b0 : (pend_led_reg  || led_req);
    pend_val_next  = led_req ? led_val : pend_val_reg;

    if (start_init || start_led) begin
      err_next = 1'b0;
    end

    // Received bytes only become scan codes while idle; otherwise they are replies.
    if (state_reg == ST_IDLE && rx_valid) begin
      scan_valid_next = 1'b1;
      scan_byte_next  = rx_byte;
    end

    case (state_reg)
      ST_IDLE: begin
        if (start_init) begin
          state_next   = ST_SEND;
          tx_byte_next = CMD_RESET;
          seq_led_next = 1'b0;
          step_next    = 1'b0;
`ifdef KBD_SEQ_RETRY_EN
          retry_cnt_next = '0;
`endif
        end else if (start_led) begin
          state_next   = ST_SEND;
          tx_byte_next = CMD_SET_LED;
          seq_led_next = 1'b1;
          step_next    = 1'b0;
          seq_val_next = led_sel;
`ifdef KBD_SEQ_RETRY_EN
          retry_cnt_next = '0;
`endif
        end
      end

      ST_SEND: begin
        if (tx_ready) begin
          state_next   = ST_WAIT_ACK;
          tmo_cnt_next = '0;
        end
      end

      ST_WAIT_ACK: begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
        if (rx_valid) begin
          if (rx_byte == RSP_ACK) begin
`ifdef KBD_SEQ_RETRY_EN
            retry_cnt_next = '0;
`endif
            if (step_reg) begin
              state_next = ST_DONE;
            end else if (!seq_led_reg) begin
              state_next   = ST_WAIT_BAT;
              tmo_cnt_next = '0;
            end else begin
              state_next   = ST_SEND;
              tx_byte_next = {5'b0, seq_val_reg};
              step_next    = 1'b1;
            end
          end else if (rx_byte == RSP_RESEND) begin
`ifdef KBD_SEQ_RETRY_EN
            // tx_byte_reg still holds the byte to resend.
            if (retry_cnt_reg == RETRY_W'(MAX_RETRY)) begin
              state_next = ST_ERR;
            end else begin
              retry_cnt_next = retry_cnt_reg + 1'b1;
              state_next     = ST_SEND;
            end
`else
            state_next = ST_ERR;
`endif
          end else begin
            state_next = ST_ERR;
          end
        end else if (tmo_cnt_reg == TMO_W'(ACK_TIMEOUT - 1)) begin
          // The state lasts exactly ACK_TIMEOUT cycles without a reply.
          state_next = ST_ERR;
        end
      end

      ST_WAIT_BAT: begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
        if (rx_valid) begin
          if (rx_byte == RSP_BAT_OK) begin
            state_next   = ST_SEND;
            tx_byte_next = CMD_ENABLE;
            step_next    = 1'b1;
          end else begin
            state_next = ST_ERR;
          end
        end else if (tmo_cnt_reg == TMO_W'(BAT_TIMEOUT - 1)) begin
          state_next = ST_ERR;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      ST_ERR: begin
        err_next   = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      tx_byte_reg    <= 8'h00;
      seq_led_reg    <= 1'b0;
      step_reg       <= 1'b0;
      seq_val_reg    <= 3'b000;
      pend_init_reg  <= 1'b0;
      pend_led_reg   <= 1'b0;
      pend_val_reg   <= 3'b000;
      tmo_cnt_reg    <= '0;
      err_reg        <= 1'b0;
      scan_valid_reg <= 1'b0;
      scan_byte_reg  <= 8'h00;
`ifdef KBD_SEQ_RETRY_EN
      retry_cnt_reg  <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      tx_byte_reg    <= tx_byte_next;
      seq_led_reg    <= seq_led_next;
      step_reg       <= step_next;
      seq_val_reg    <= seq_val_next;
      pend_init_reg  <= pend_init_next;
      pend_led_reg   <= pend_led_next;
      pend_val_reg   <= pend_val_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      err_reg        <= err_next;
      scan_valid_reg <= scan_valid_next;
      scan_byte_reg  <= scan_byte_next;
`ifdef KBD_SEQ_RETRY_EN
      retry_cnt_reg  <= retry_cnt_next;
`endif
    end
  end

  assign tx_valid   = (state_reg == ST_SEND);
  assign tx_byte    = tx_byte_reg;
  assign scan_valid = scan_valid_reg;
  assign scan_byte  = scan_byte_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign err        = err_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_kbd_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_kbd_cmd_seq
//   Scoreboard bench for kbd_cmd_seq. Each test pushes the expected DUT events
//   (transmitted bytes, done, err, forwarded scan codes) to exp_q and the
//   device replies it should give to resp_q. A monitor pops exp_q as events
//   appear; a responder plays the keyboard side.
//   Event coding: 0..255 tx byte, 256 done, 257 ERR state, 512+b scan code.
// -----------------------------------------------------------------------------
module tb_kbd_cmd_seq;

  localparam int ACK_TO = 100;
  localparam int BAT_TO = 500;
  localparam int EV_DONE = 256;
  localparam int EV_ERR  = 257;
  localparam int EV_SCAN = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_req = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic       tx_ready = 1'b1;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       scan_valid;
  logic [7:0] scan_byte;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int resp_q[$];
  int inj_q[$];

  kbd_cmd_seq #(
    .ACK_TIMEOUT(ACK_TO),
    .BAT_TIMEOUT(BAT_TO),
    .MAX_RETRY  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_req  (init_req),
    .led_req   (led_req),
    .led_val   (led_val),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_byte   (tx_byte),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .scan_valid(scan_valid),
    .scan_byte (scan_byte),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reply descriptor: n bytes (0..2), b0 first, then b1.
  function automatic int rsp(input int n, input int b0, input int b1);
    return (n << 16) | ((b1 & 255) << 8) | (b0 & 255);
  endfunction

  task automatic log_evt(input string kind, input int got);
    $display("evt %s 0x%02h", kind, got & 255);
    if (exp_q.size() == 0) check({"unexpected_", kind}, got, -1);
    else check({"seq_", kind}, got, exp_q.pop_front());
  endtask

  // Monitor: samples DUT outputs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_valid && tx_ready) log_evt("tx", int'(tx_byte));
        if (done) log_evt("done", EV_DONE);
        if (state == 3'd5) log_evt("err", EV_ERR);
        if (scan_valid) log_evt("scan", EV_SCAN + int'(scan_byte));
      end
    end
  end

  task automatic send_rx(input int b);
    rx_valid = 1'b1;
    rx_byte  = b[7:0];
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Keyboard model: one reply descriptor per accepted byte; idle injections
  // become unsolicited scan codes.
  initial begin
    @(negedge clk);
    forever begin
      if (!rst && tx_valid && tx_ready) begin
        int e;
        int n;
        e = 0;
        if (resp_q.size() > 0) e = resp_q.pop_front();
        n = e >> 16;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
          @(negedge clk);
          @(negedge clk);
          send_rx((e >> (8 * k)) & 255);
        end
      end else if (!rst && !busy && inj_q.size() > 0) begin
        send_rx(inj_q.pop_front());
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
  endtask

  task automatic pulse_led(input logic [2:0] v);
    led_req = 1'b1;
    led_val = v;
    tick();
    led_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_state", int'(state), 0);
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_tx_byte", int'(tx_byte), 0);
    check("rst_scan_valid", int'(scan_valid), 0);
    check("rst_scan_byte", int'(scan_byte), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    tick();

    // Init sequence
    resp_q.push_back(rsp(2, 8'hFA, 8'hAA));
    resp_q.push_back(rsp(1, 8'hFA, 0));
    exp_q.push_back(8'hFF); exp_q.push_back(8'hF4); exp_q.push_back(EV_DONE);
    pulse_init();
    check("init_busy", int'(busy), 1);
    wait_idle(2000, "init");
    check("init_err", int'(err), 0);
    check("init_busy_after", int'(busy), 0);

    // LED sequence, with tx_ready held low first to check SEND holds the byte
    tx_ready = 1'b0;
    resp_q.push_back(rsp(1, 8'hFA, 0));
    resp_q.push_back(rsp(1, 8'hFA, 0));
    exp_q.push_back(8'hED); exp_q.push_back(8'h05); exp_q.push_back(EV_DONE);
    pulse_led(3'b101);
    repeat (4) tick();
    check("stall_state", int'(state), 1);
    check("stall_tx_valid", int'(tx_valid), 1);
    check("stall_tx_byte", int'(tx_byte), 8'hED);
    tx_ready = 1'b1;
    wait_idle(500, "led");
    check("led_err", int'(err), 0);

    // Simultaneous init+led, then a newer led_req while busy (latest value wins)
    resp_q.push_back(rsp(2, 8'hFA, 8'hAA));
    resp_q.push_back(rsp(1, 8'hFA, 0));
    resp_q.push_back(rsp(1, 8'hFA, 0));
    resp_q.push_back(rsp(1, 8'hFA, 0));
    exp_q.push_back(8'hFF); exp_q.push_back(8'hF4); exp_q.push_back(EV_DONE);
    exp_q.push_back(8'hED); exp_q.push_back(8'h06); exp_q.push_back(EV_DONE);
    init_req = 1'b1;
    pulse_led(3'b011);
    init_req = 1'b0;
    repeat (3) tick();
    pulse_led(3'b110);
    wait_idle(3000, "both");

    // No reply: ERR exactly ACK_TO cycles after the ED handshake
    begin
      bit seen;
      int cnt;
      resp_q.push_back(rsp(0, 0, 0));
      exp_q.push_back(8'hED); exp_q.push_back(EV_ERR);
      pulse_led(3'b001);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        if (tx_valid && tx_ready) seen = 1'b1;
        else tick();
      end
      check("tmo_handshake_seen", int'(seen), 1);
      tick();
      cnt = 0;
      for (int i = 0; i < 3 * ACK_TO; i++) begin
        tick();
        cnt++;
        if (state == 3'd5) break;
      end
      check("ack_timeout_cycles", cnt, ACK_TO);
      tick();
      check("tmo_err_set", int'(err), 1);
      wait_idle(50, "tmo");
      check("tmo_err_sticky", int'(err), 1);
      resp_q.push_back(rsp(1, 8'hFA, 0));
      resp_q.push_back(rsp(1, 8'hFA, 0));
      exp_q.push_back(8'hED); exp_q.push_back(8'h02); exp_q.push_back(EV_DONE);
      pulse_led(3'b010);
      check("err_cleared", int'(err), 0);
      wait_idle(500, "after_tmo");
    end

    // Resend handling
`ifdef KBD_SEQ_RETRY_EN
    resp_q.push_back(rsp(1, 8'hFE, 0));
    resp_q.push_back(rsp(1, 8'hFE, 0));
    resp_q.push_back(rsp(1, 8'hFA, 0));
    resp_q.push_back(rsp(1, 8'hFA, 0));
    exp_q.push_back(8'hED); exp_q.push_back(8'hED); exp_q.push_back(8'hED);
    exp_q.push_back(8'h07); exp_q.push_back(EV_DONE);
    pulse_led(3'b111);
    wait_idle(1000, "retry");
    check("retry_err", int'(err), 0);
`else
    resp_q.push_back(rsp(1, 8'hFE, 0));
    exp_q.push_back(8'hED); exp_q.push_back(EV_ERR);
    pulse_led(3'b111);
    wait_idle(500, "resend");
    check("resend_err", int'(err), 1);
`endif

    // Scan forwarding in IDLE
    inj_q.push_back(8'h1C);
    exp_q.push_back(EV_SCAN + 8'h1C);
    wait_idle(50, "scan");

    // Reset during WAIT_BAT: abort without done or err
    begin
      bit seen;
      resp_q.push_back(rsp(1, 8'hFA, 0));
      exp_q.push_back(8'hFF);
      pulse_init();
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        if (state == 3'd3) seen = 1'b1;
        else tick();
      end
      check("reach_wait_bat", int'(state), 3);
      rst = 1'b1;
      tick();
      check("rst_bat_state", int'(state), 0);
      check("rst_bat_busy", int'(busy), 0);
      check("rst_bat_done", int'(done), 0);
      check("rst_bat_err", int'(err), 0);
      rst = 1'b0;
      repeat (20) tick();
      check("rst_bat_state_after", int'(state), 0);
    end

    check("exp_q_empty", exp_q.size(), 0);
    check("resp_q_empty", resp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/kbd_cmd_seq.md
KBD_CMD_SEQ -- requirements
Module: kbd_cmd_seq

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1000000: cycles to wait for a device response byte after each transmitted byte.
REQ-002 Parameter BAT_TIMEOUT, default 40000000: cycles to wait for self-test result 8'hAA after the reset command is acknowledged.
REQ-003 Parameter MAX_RETRY, default 3: resends allowed per byte on 8'hFE.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 init_req  in  1  pulse: run the init sequence (FF, BAT, F4).
REQ-007 led_req  in  1  pulse: run the LED sequence (ED, value).
REQ-008 led_val  in  3  {caps,num,scroll}; sampled on the cycle led_req is accepted.
REQ-009 tx_ready  in  1  byte engine idle and able to accept a byte.
REQ-010 tx_valid  out  1  byte offered to the engine.
REQ-011 tx_byte  out  8  byte to transmit.
REQ-012 rx_valid  in  1  one-cycle strobe: rx_byte is a received byte.
REQ-013 rx_byte  in  8  received byte.
REQ-014 scan_valid  out  1  one-cycle strobe: scan_byte is a non-command byte.
REQ-015 scan_byte  out  8  forwarded scan code.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 done  out  1  one-cycle pulse on successful sequence completion.
REQ-018 err  out  1  sticky; set on failure, cleared when the next request is accepted.
REQ-019 state  out  3  debug encoding: 0 IDLE, 1 SEND, 2 WAIT_ACK, 3 WAIT_BAT, 4 DONE, 5 ERR.

Function
REQ-020 The init sequence SHALL transmit FF, await FA, await AA within BAT_TIMEOUT, transmit F4, then await FA.
REQ-021 The LED sequence SHALL transmit ED, await FA, transmit {5'b0,led_val}, then await FA.
REQ-022 SEND SHALL hold tx_valid high with tx_byte stable until the cycle in which tx_valid and tx_ready are both high; tx_valid SHALL be low on the following cycle, when the state moves to WAIT_ACK.
REQ-023 The timeout counter (26 bits) SHALL clear on each entry to WAIT_ACK or WAIT_BAT and increment every cycle in those states; reaching the limit SHALL enter ERR.
REQ-024 In WAIT_ACK, FA SHALL advance the sequence; FE SHALL be handled per REQ-035/036; any other byte SHALL enter ERR.
REQ-025 In WAIT_BAT, AA SHALL advance the sequence; FC or any other byte SHALL enter ERR.
REQ-026 DONE SHALL last one cycle, assert done, then return to IDLE.
REQ-027 ERR SHALL last one cycle, set err, abandon the sequence, then return to IDLE.
REQ-028 In IDLE, every rx byte SHALL be forwarded on scan_valid/scan_byte in the following cycle; in any other state, rx bytes SHALL be consumed and not forwarded.
REQ-029 Simultaneous init_req and led_req in IDLE: init SHALL be accepted and led SHALL become pending.
REQ-030 A request arriving while busy SHALL set a one-deep pending flag for its type; a pending led SHALL keep the latest led_val.
REQ-031 On return to IDLE, pending init SHALL start before pending led, and a pending request SHALL start on the cycle after IDLE is entered.
REQ-032 A pending request that started SHALL clear its flag; a completed init SHALL NOT clear a pending led.

Reset
REQ-033 rst SHALL force state IDLE, clear pending flags, retry count and timeout counter, and set tx_valid, scan_valid, done and err to 0 and tx_byte and scan_byte to 8'h00.
REQ-034 rst asserted mid-sequence SHALL abort it on the next clock edge without emitting done or err.

Configuration
REQ-035 With macro KBD_SEQ_RETRY_EN defined, FE in WAIT_ACK SHALL resend the same byte via SEND; the MAX_RETRY+1-th FE for that byte SHALL enter ERR; the retry count SHALL clear on each FA.
REQ-036 Without KBD_SEQ_RETRY_EN, FE in WAIT_ACK SHALL enter ERR immediately, and no retry counter SHALL exist.

Verification (ACK_TIMEOUT=100, BAT_TIMEOUT=500)
REQ-037 init_req; respond FA, AA, FA -> tx bytes FF then F4, one done pulse, err=0, busy low afterwards.
REQ-038 led_req with led_val=3'b101; respond FA, FA -> tx bytes ED then 05, done pulse.
REQ-039 init_req and led_req in the same cycle -> FF, F4, ED, then the led byte, with two done pulses in order.
REQ-040 led_req with no response -> ERR exactly 100 cycles after the ED handshake, err=1; a following led_req clears err.
REQ-041 With RETRY_EN, respond FE, FE, FA to ED -> ED sent three times, then the sequence completes; without RETRY_EN, the first FE -> err.
REQ-042 IDLE with rx 1C -> scan_valid with 1C; rst during WAIT_BAT -> IDLE next cycle, no done or err.
